// File: rtl/route4.sv
// route4: 4-phase handshake router forwarding one upstream transfer to one of four
// downstream channels, selected by a 2-bit field of the payload.
module route4 #(
   parameter int data_width = 32,
   parameter int dest_lsb   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_req,
   input  logic [data_width-1:0] in_data,
   output logic                  in_ack,
   output logic                  outA_req,
   output logic                  outB_req,
   output logic                  outC_req,
   output logic                  outD_req,
   output logic [data_width-1:0] outA_data,
   output logic [data_width-1:0] outB_data,
   output logic [data_width-1:0] outC_data,
   output logic [data_width-1:0] outD_data,
   input  logic                  outA_ack,
   input  logic                  outB_ack,
   input  logic                  outC_ack,
   input  logic                  outD_ack,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OUT_REQ = 2'd1,
      OUT_RTZ = 2'd2,
      IN_ACK  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [data_width-1:0] data_q, data_d;
   logic [1:0]            dest_q, dest_d;
   logic [3:0]            req_q, req_d;
   logic                  in_ack_q, in_ack_d;
   logic                  busy_q, busy_d;
   logic [3:0]            ack_s;
   logic                  sel_ack_s;

   // Only the acknowledge of the latched destination is ever looked at.
   assign ack_s     = {outD_ack, outC_ack, outB_ack, outA_ack};
   assign sel_ack_s = ack_s[dest_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         data_q   <= '0;
         dest_q   <= 2'd0;
         req_q    <= 4'd0;
         in_ack_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         dest_q   <= dest_d;
         req_q    <= req_d;
         in_ack_q <= in_ack_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      dest_d  = dest_q;
      case (state_q)
         IDLE: begin
            if (in_req) begin
               data_d  = in_data;
               dest_d  = in_data[dest_lsb +: 2];
               state_d = OUT_REQ;
            end else begin
               state_d = IDLE;
            end
         end
         OUT_REQ: begin
            if (sel_ack_s) begin
               state_d = OUT_RTZ;
            end else begin
               state_d = OUT_REQ;
            end
         end
         OUT_RTZ: begin
            if (!sel_ack_s) begin
               state_d = IN_ACK;
            end else begin
               state_d = OUT_RTZ;
            end
         end
         IN_ACK: begin
            if (!in_req) begin
               state_d = IDLE;
            end else begin
               state_d = IN_ACK;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Request is issued one cycle after entering OUT_REQ and withdrawn on the
   // edge that sees the acknowledge; in_ack and busy follow the next state.
   always_comb begin
      req_d    = 4'd0;
      in_ack_d = (state_d == IN_ACK);
      busy_d   = (state_d != IDLE);
      if ((state_q == OUT_REQ) && !sel_ack_s) begin
         req_d[dest_q] = 1'b1;
      end else begin
         req_d = 4'd0;
      end
   end

   assign in_ack    = in_ack_q;
   assign busy      = busy_q;
   assign outA_req  = req_q[0];
   assign outB_req  = req_q[1];
   assign outC_req  = req_q[2];
   assign outD_req  = req_q[3];
   assign outA_data = data_q;
   assign outB_data = data_q;
   assign outC_data = data_q;
   assign outD_data = data_q;

endmodule

// File: tb/tb_route4.sv
// Randomised self-checking bench for route4: behavioural sender, auto-responding
// downstream channels and an expected-delivery queue.
module tb_route4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_req;
   logic [31:0] in_data;
   logic        in_ack;
   logic [3:0]  o_req;
   logic [31:0] o_data [4];
   logic [3:0]  o_ack;
   logic        busy;

   logic        in_req4;
   logic [31:0] in_data4;
   logic        in_ack4;
   logic [3:0]  o_req4;
   logic [31:0] o_data4 [4];
   logic [3:0]  o_ack4;
   logic        busy4;

   logic        resp_en;
   logic [3:0]  ack_auto;
   logic [3:0]  ack_force;
   logic [3:0]  prev_req;
   int          rise_cnt [4];

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          dest;
      logic [31:0] data;
   } exp_t;
   exp_t exp_q [$];

   assign o_ack = ack_auto | ack_force;

   always #5 clk = ~clk;

   route4 #(.data_width(32), .dest_lsb(0)) u_dut (
      .clk(clk), .rst(rst), .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
      .outA_req(o_req[0]), .outB_req(o_req[1]), .outC_req(o_req[2]), .outD_req(o_req[3]),
      .outA_data(o_data[0]), .outB_data(o_data[1]), .outC_data(o_data[2]), .outD_data(o_data[3]),
      .outA_ack(o_ack[0]), .outB_ack(o_ack[1]), .outC_ack(o_ack[2]), .outD_ack(o_ack[3]),
      .busy(busy)
   );

   route4 #(.data_width(32), .dest_lsb(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_req(in_req4), .in_data(in_data4), .in_ack(in_ack4),
      .outA_req(o_req4[0]), .outB_req(o_req4[1]), .outC_req(o_req4[2]), .outD_req(o_req4[3]),
      .outA_data(o_data4[0]), .outB_data(o_data4[1]), .outC_data(o_data4[2]), .outD_data(o_data4[3]),
      .outA_ack(o_ack4[0]), .outB_ack(o_ack4[1]), .outC_ack(o_ack4[2]), .outD_ack(o_ack4[3]),
      .busy(busy4)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Downstream channels: raise ack some cycles after req, drop it after req falls.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (resp_en) begin
            if (o_req[i] && !ack_auto[i] && ($urandom_range(0, 2) == 0)) ack_auto[i] = 1'b1;
            else if (!o_req[i] && ack_auto[i] && ($urandom_range(0, 2) == 0)) ack_auto[i] = 1'b0;
         end
      end
   end

   // Every req rising edge must match the oldest outstanding expected delivery.
   always @(negedge clk) begin
      check_val("req_onehot", 32'($countones(o_req) <= 1), 32'd1);
      for (int i = 0; i < 4; i++) begin
         if (o_req[i] && !prev_req[i]) begin
            rise_cnt[i]++;
            if (exp_q.size() == 0) begin
               check_val("spurious_req", 32'(i), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check_val("route_dest", 32'(i), 32'(e.dest));
               for (int j = 0; j < 4; j++) check_val("out_data", o_data[j], e.data);
            end
         end
      end
      prev_req = o_req;
   end

   task automatic wait_in_ack(input logic level, input string tag);
      int n = 0;
      while ((in_ack !== level) && (n < 300)) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check_val(tag, 32'(in_ack), 32'(level));
   endtask

   task automatic send(input logic [31:0] d, input logic [31:0] scramble, input logic early_drop);
      int dest;
      dest = int'(d % 32'd4);
      @(negedge clk);
      in_data = d;
      in_req  = 1'b1;
      exp_q.push_back('{dest, d});
      @(negedge clk);
      check_val("busy_after_capture", 32'(busy), 32'd1);
      check_val("req_not_yet", 32'(o_req), 32'd0);
      in_data = scramble;
      if (early_drop) in_req = 1'b0;
      @(negedge clk);
      check_val("req_latency", 32'(o_req), 32'd1 << dest);
      check_val("data_held", o_data[dest], d);
      wait_in_ack(1'b1, "timeout_in_ack_rise");
      if (!early_drop) in_req = 1'b0;
      @(negedge clk);
      check_val("in_ack_fall", 32'(in_ack), 32'd0);
      check_val("busy_idle", 32'(busy), 32'd0);
      check_val("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int cnt0 [4];
      int n;
      logic [31:0] d;
      rst = 1'b1; in_req = 1'b0; in_data = 32'd0;
      in_req4 = 1'b0; in_data4 = 32'd0; o_ack4 = 4'd0;
      resp_en = 1'b1; ack_auto = 4'd0; ack_force = 4'd0; prev_req = 4'd0;
      for (int i = 0; i < 4; i++) rise_cnt[i] = 0;
      repeat (3) @(negedge clk);
      check_val("rst_in_ack", 32'(in_ack), 32'd0);
      check_val("rst_req", 32'(o_req), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_data_a", o_data[0], 32'd0);
      rst = 1'b0;

      send(32'h0000_0002, 32'h0000_0002, 1'b0);

      for (int i = 0; i < 4; i++) cnt0[i] = rise_cnt[i];
      send(32'h0000_00A0, 32'h0, 1'b0);
      send(32'h0000_00B1, 32'h0, 1'b0);
      send(32'h0000_00C2, 32'h0, 1'b0);
      send(32'h0000_00D3, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) check_val("one_req_per_xfer", 32'(rise_cnt[i] - cnt0[i]), 32'd1);

      // Stuck ack on B must not move a transfer routed to A.
      resp_en = 1'b0;
      @(negedge clk);
      ack_force = 4'b0010;
      in_data = 32'h0000_0104;
      in_req = 1'b1;
      exp_q.push_back('{0, 32'h0000_0104});
      repeat (8) @(negedge clk);
      check_val("b_ack_ignored_req", 32'(o_req), 32'd1);
      check_val("b_ack_ignored_ack", 32'(in_ack), 32'd0);
      resp_en = 1'b1;
      wait_in_ack(1'b1, "timeout_a_xfer");
      in_req = 1'b0;
      @(negedge clk);
      check_val("a_xfer_done", 32'(busy), 32'd0);
      ack_force = 4'd0;

      send(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
      send(32'h0000_5553, 32'h0, 1'b1);

      // Reset in OUT_REQ aborts the transfer.
      resp_en = 1'b0;
      @(negedge clk);
      in_data = 32'h0000_0003;
      in_req = 1'b1;
      exp_q.push_back('{3, 32'h0000_0003});
      repeat (2) @(negedge clk);
      check_val("pre_rst_req", 32'(o_req), 32'b1000);
      rst = 1'b1;
      in_req = 1'b0;
      @(negedge clk);
      check_val("mid_rst_req", 32'(o_req), 32'd0);
      check_val("mid_rst_ack", 32'(in_ack), 32'd0);
      check_val("mid_rst_busy", 32'(busy), 32'd0);
      for (int j = 0; j < 4; j++) check_val("mid_rst_data", o_data[j], 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_val("post_rst_idle", 32'(busy), 32'd0);
      resp_en = 1'b1;
      send(32'h1234_5679, 32'h0, 1'b0);

      for (int k = 0; k < 40; k++) begin
         d = $urandom;
         @(negedge clk);
         ack_force = 4'($urandom) & ~(4'd1 << d[1:0]);
         send(d, $urandom, 1'($urandom_range(0, 3) == 0));
         ack_force = 4'd0;
      end

      // Destination field at bit 4.
      @(negedge clk);
      in_data4 = 32'h0000_0030;
      in_req4 = 1'b1;
      n = 0;
      while ((o_req4 == 4'd0) && (n < 50)) begin @(negedge clk); n++; end
      check_val("lsb4_route", 32'(o_req4), 32'b1000);
      check_val("lsb4_data", o_data4[3], 32'h0000_0030);
      o_ack4[3] = 1'b1;
      n = 0;
      while ((o_req4 != 4'd0) && (n < 50)) begin @(negedge clk); n++; end
      check_val("lsb4_req_drop", 32'(o_req4), 32'd0);
      o_ack4 = 4'd0;
      n = 0;
      while (!in_ack4 && (n < 50)) begin @(negedge clk); n++; end
      check_val("lsb4_in_ack", 32'(in_ack4), 32'd1);
      in_req4 = 1'b0;
      @(negedge clk);
      check_val("lsb4_idle", 32'({in_ack4, busy4}), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
